// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types for the instruction fetch stage: FSM states, PC/instruction
// widths and the IF/ID pipeline register layout.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HOLD,
        S_FAULT
    } fetch_state_t;

    typedef logic [63:0] pc_t;
    typedef logic [31:0] instr_t;

    typedef struct packed {
        pc_t    pc;
        instr_t instr;
        logic   valid;
    } ifid_t;

    // A fetch target is aligned when it sits on a 4-byte boundary.
    function automatic logic pc_is_aligned(input pc_t pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// IF/ID handshake towards decode.
// Valid/ready contract: a transfer happens on a clock edge where
// if_valid_o && if_ready_i; while if_valid_o=1 and if_ready_i=0 the
// producer keeps if_pc_o and if_instr_o stable until the transfer.
interface instruction_fetch_stage_if;
    import fetch_pkg::*;

    logic   if_valid_o;
    pc_t    if_pc_o;
    instr_t if_instr_o;
    logic   if_ready_i;

    modport master (
        output if_valid_o,
        output if_pc_o,
        output if_instr_o,
        input  if_ready_i
    );

    modport slave (
        input  if_valid_o,
        input  if_pc_o,
        input  if_instr_o,
        output if_ready_i
    );

endinterface

// File: rtl/instruction_fetch_stage_pc_register.sv
// Program counter register: load wins over increment, otherwise hold.
// Increment wraps modulo 2^64 with no overflow indication.
module pc_register
    import fetch_pkg::*;
#(
    parameter pc_t         RESET_PC = 64'h0,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  pc_t  load_pc_i,
    input  logic inc_i,
    output pc_t  pc_o
);

    pc_t pc_q;
    pc_t pc_d;

    // Next PC selection.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            pc_d = pc_q + pc_t'(PC_STEP);
        end
    end

    // PC state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory
// address combinationally and captures {pc, instr} into IF/ID.
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- misaligned redirect
// targets raise fault_o and freeze the stage until reset.
module instruction_fetch_stage
    import fetch_pkg::*;
#(
    parameter pc_t         RESET_PC = 64'h0,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output pc_t                        imem_adr,
    input  instr_t                     imem_instr,
    input  logic                       stall_i,
    input  logic                       redirect_i,
    input  pc_t                        redirect_pc_i,
    instruction_fetch_stage_if.master  ifid,
    output logic                       fault_o,
    output fetch_state_t               state_o
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    ifid_t        ifid_q;
    ifid_t        ifid_d;
    pc_t          pc;
    logic         pc_load;
    logic         pc_inc;
    logic         advance;
    logic         transfer;
`ifdef FETCH_ALIGN_CHECK_EN
    logic         fault_q;
    logic         fault_d;
`endif

    pc_register #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (pc_load),
        .load_pc_i (redirect_pc_i),
        .inc_i     (pc_inc),
        .pc_o      (pc)
    );

    assign advance  = !stall_i && (!ifid_q.valid || ifid.if_ready_i);
    assign transfer = ifid_q.valid && ifid.if_ready_i;

    // Next-state and control: redirect beats advance beats hold.
    always_comb begin
        state_d = state_q;
        ifid_d  = ifid_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d = fault_q;
`endif
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN, S_HOLD: begin
                if (redirect_i) begin
                    // Squash IF/ID; the redirect also overrides a stall.
                    ifid_d.valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (!pc_is_aligned(redirect_pc_i)) begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        pc_load = 1'b1;
                        state_d = S_RUN;
                    end
`else
                    pc_load = 1'b1;
                    state_d = S_RUN;
`endif
                end else if (advance) begin
                    ifid_d  = '{pc: pc, instr: imem_instr, valid: 1'b1};
                    pc_inc  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    // Decode took the entry while stalled: empty IF/ID.
                    if (transfer) begin
                        ifid_d.valid = 1'b0;
                    end
                    state_d = S_HOLD;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // FSM state and IF/ID register; reset discards IF/ID without draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            ifid_q  <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ifid_q  <= ifid_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign imem_adr        = pc;
    assign ifid.if_valid_o = ifid_q.valid;
    assign ifid.if_pc_o    = ifid_q.pc;
    assign ifid.if_instr_o = ifid_q.instr;
    assign state_o         = state_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fault_o         = fault_q;
`else
    assign fault_o         = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: a vector table for the main
// sequential/backpressure/redirect/wrap behaviour plus hand sequences for
// misaligned redirects and reset in the middle of operation.
module tb_instruction_fetch_stage;
    import fetch_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    pc_t          imem_adr;
    instr_t       imem_instr;
    logic         stall_i;
    logic         redirect_i;
    pc_t          redirect_pc_i;
    logic         fault_o;
    fetch_state_t state_o;

    int checks = 0;
    int errors = 0;

    instruction_fetch_stage_if ifid ();

    instruction_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_adr      (imem_adr),
        .imem_instr    (imem_instr),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ifid          (ifid),
        .fault_o       (fault_o),
        .state_o       (state_o)
    );

    // Clock.
    always #5 clk = ~clk;

    // Memory model: returns A000_0000 + address in the same cycle.
    function automatic instr_t mem_word(input pc_t adr);
        return 32'hA000_0000 + adr[31:0];
    endfunction

    assign imem_instr = mem_word(imem_adr);

    typedef struct {
        logic         stall;
        logic         redir;
        pc_t          rpc;
        logic         ready;
        logic         exp_valid;
        pc_t          exp_pc;
        pc_t          exp_adr;
        fetch_state_t exp_state;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic stall, input logic redir, input pc_t rpc, input logic ready);
        stall_i         = stall;
        redirect_i      = redir;
        redirect_pc_i   = rpc;
        ifid.if_ready_i = ready;
    endtask

    function automatic vec_t mk(input logic stall, input logic redir, input pc_t rpc,
                                input logic ready, input logic ev, input pc_t epc,
                                input pc_t eadr, input fetch_state_t est);
        vec_t v;
        v.stall = stall; v.redir = redir; v.rpc = rpc; v.ready = ready;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_adr = eadr; v.exp_state = est;
        return v;
    endfunction

    initial begin
        // Table: starts with pc=0 in S_RUN and IF/ID empty.
        // sequential fetch
        vecs[0]  = mk(0, 0, 64'h0,   1, 1, 64'h0,   64'h4,   S_RUN);
        vecs[1]  = mk(0, 0, 64'h0,   1, 1, 64'h4,   64'h8,   S_RUN);
        // backpressure at pc=8 for 3 cycles
        vecs[2]  = mk(0, 0, 64'h0,   0, 1, 64'h4,   64'h8,   S_HOLD);
        vecs[3]  = mk(0, 0, 64'h0,   0, 1, 64'h4,   64'h8,   S_HOLD);
        vecs[4]  = mk(0, 0, 64'h0,   0, 1, 64'h4,   64'h8,   S_HOLD);
        vecs[5]  = mk(0, 0, 64'h0,   1, 1, 64'h8,   64'hC,   S_RUN);
        vecs[6]  = mk(0, 0, 64'h0,   1, 1, 64'hC,   64'h10,  S_RUN);
        // redirect together with stall
        vecs[7]  = mk(1, 1, 64'h100, 1, 0, 64'hC,   64'h100, S_RUN);
        vecs[8]  = mk(0, 0, 64'h0,   1, 1, 64'h100, 64'h104, S_RUN);
        // stall with transfer empties IF/ID, pc holds
        vecs[9]  = mk(1, 0, 64'h0,   1, 0, 64'h100, 64'h104, S_HOLD);
        vecs[10] = mk(1, 0, 64'h0,   0, 0, 64'h100, 64'h104, S_HOLD);
        // empty IF/ID advances even with ready low
        vecs[11] = mk(0, 0, 64'h0,   0, 1, 64'h104, 64'h108, S_RUN);
        vecs[12] = mk(1, 0, 64'h0,   0, 1, 64'h104, 64'h108, S_HOLD);
        // wrap of the PC at the top of the address space
        vecs[13] = mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h104, 64'hFFFF_FFFF_FFFF_FFFC, S_RUN);
        vecs[14] = mk(0, 0, 64'h0,   1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, S_RUN);
        vecs[15] = mk(0, 0, 64'h0,   1, 1, 64'h0,   64'h4,   S_RUN);

        // Reset held for two cycles.
        rst_n = 1'b0;
        drive(0, 0, 64'h0, 1);
        tick();
        tick();
        chk("rst_valid", 64'(ifid.if_valid_o), 64'h0);
        chk("rst_pc",    ifid.if_pc_o,         64'h0);
        chk("rst_instr", 64'(ifid.if_instr_o), 64'h0);
        chk("rst_fault", 64'(fault_o),         64'h0);
        chk("rst_adr",   imem_adr,             64'h0);
        chk("rst_state", 64'(state_o),         64'(S_BOOT));

        // First cycle after release: boot, no capture.
        rst_n = 1'b1;
        tick();
        chk("boot_valid", 64'(ifid.if_valid_o), 64'h0);
        chk("boot_adr",   imem_adr,             64'h0);
        chk("boot_state", 64'(state_o),         64'(S_RUN));

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
            tick();
            chk($sformatf("v%0d_valid", i), 64'(ifid.if_valid_o), 64'(vecs[i].exp_valid));
            chk($sformatf("v%0d_pc", i),    ifid.if_pc_o,         vecs[i].exp_pc);
            chk($sformatf("v%0d_instr", i), 64'(ifid.if_instr_o), 64'(mem_word(vecs[i].exp_pc)));
            chk($sformatf("v%0d_adr", i),   imem_adr,             vecs[i].exp_adr);
            chk($sformatf("v%0d_state", i), 64'(state_o),         64'(vecs[i].exp_state));
            chk($sformatf("v%0d_fault", i), 64'(fault_o),         64'h0);
        end

        // Misaligned redirect: pc=4, IF/ID holds pc 0 valid.
`ifdef FETCH_ALIGN_CHECK_EN
        drive(0, 1, 64'h102, 1);
        tick();
        chk("mis_fault", 64'(fault_o),         64'h1);
        chk("mis_valid", 64'(ifid.if_valid_o), 64'h0);
        chk("mis_adr",   imem_adr,             64'h4);
        chk("mis_state", 64'(state_o),         64'(S_FAULT));
        drive(0, 1, 64'h200, 1);
        tick();
        tick();
        chk("flt_fault", 64'(fault_o),         64'h1);
        chk("flt_valid", 64'(ifid.if_valid_o), 64'h0);
        chk("flt_adr",   imem_adr,             64'h4);
        chk("flt_pc",    ifid.if_pc_o,         64'h0);
        chk("flt_state", 64'(state_o),         64'(S_FAULT));
        drive(0, 0, 64'h0, 1);
`else
        drive(0, 1, 64'h102, 1);
        tick();
        chk("mis_fault", 64'(fault_o),         64'h0);
        chk("mis_valid", 64'(ifid.if_valid_o), 64'h0);
        chk("mis_adr",   imem_adr,             64'h102);
        drive(0, 0, 64'h0, 1);
        tick();
        chk("mis_cap_valid", 64'(ifid.if_valid_o), 64'h1);
        chk("mis_cap_pc",    ifid.if_pc_o,         64'h102);
        chk("mis_cap_instr", 64'(ifid.if_instr_o), 64'hA000_0102);
        chk("mis_cap_adr",   imem_adr,             64'h106);
        chk("mis_cap_fault", 64'(fault_o),         64'h0);
`endif

        // Reset mid-operation discards IF/ID immediately.
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 64'(ifid.if_valid_o), 64'h0);
        chk("mid_rst_pc",    ifid.if_pc_o,         64'h0);
        chk("mid_rst_adr",   imem_adr,             64'h0);
        chk("mid_rst_fault", 64'(fault_o),         64'h0);
        chk("mid_rst_state", 64'(state_o),         64'(S_BOOT));

        // Restart: valid on the second cycle after release.
        rst_n = 1'b1;
        tick();
        chk("re_boot_valid", 64'(ifid.if_valid_o), 64'h0);
        tick();
        chk("re_run_valid", 64'(ifid.if_valid_o), 64'h1);
        chk("re_run_pc",    ifid.if_pc_o,         64'h0);
        chk("re_run_instr", 64'(ifid.if_instr_o), 64'hA000_0000);
        chk("re_run_adr",   imem_adr,             64'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
